// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - two-stage issue/result pipeline wrapped around an external ALU
module alu_issue_stage #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] in_a,
    input  logic [BUS_WIDTH-1:0] in_b,
    input  logic [3:0]           in_opcode,
    input  logic                 in_use_carry,
    input  logic                 clr_flags,
    output logic [BUS_WIDTH-1:0] alu_a,
    output logic [BUS_WIDTH-1:0] alu_b,
    output logic [3:0]           alu_opcode,
    output logic                 alu_carry_in,
    input  logic [BUS_WIDTH-1:0] alu_y,
    input  logic                 alu_carry_out,
    input  logic                 alu_borrow,
    input  logic                 alu_zero,
    input  logic                 alu_parity,
    input  logic                 alu_invalid_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_y,
    output logic [4:0]           out_flags,
    output logic [7:0]           err_count,
    output logic                 carry_flag
);

    logic s1_valid;
    logic s2_valid;
    logic s1_use_carry;
    logic carry_hold;
    logic c_flag;
    logic s2_free;
    logic load_s1;
    logic move_s2;
    logic carry_op;

    assign s2_free   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_free;
    assign load_s1   = in_valid && in_ready;
    assign move_s2   = s1_valid && s2_free;
    assign out_valid = s2_valid;
    assign carry_flag = c_flag;
    assign carry_op  = (alu_opcode == 4'd2) || (alu_opcode == 4'd4);

    // C is read live so an op following a carry-producing op sees the fresh value;
    // once S1 drains the last driven value is held.
    assign alu_carry_in = s1_valid ? (s1_use_carry && c_flag) : carry_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_opcode   <= 4'd0;
            s1_use_carry <= 1'b0;
            carry_hold   <= 1'b0;
        end else begin
            if (s1_valid) begin
                carry_hold <= s1_use_carry && c_flag;
            end
            if (load_s1) begin
                s1_valid     <= 1'b1;
                alu_a        <= in_a;
                alu_b        <= in_b;
                alu_opcode   <= in_opcode;
                s1_use_carry <= in_use_carry;
            end else if (move_s2) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_y     <= '0;
            out_flags <= 5'd0;
        end else if (move_s2) begin
            s2_valid  <= 1'b1;
            out_y     <= alu_y;
            out_flags <= {alu_invalid_op, alu_parity, alu_zero, alu_borrow, alu_carry_out};
        end else if (s2_valid && out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Clear has priority over a same-edge carry update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_flag <= 1'b0;
        end else if (clr_flags) begin
            c_flag <= 1'b0;
        end else if (move_s2 && carry_op) begin
            c_flag <= alu_carry_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (move_s2 && alu_invalid_op && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage with a behavioural ALU
module tb_alu_issue_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic [3:0] in_opcode = 4'd0;
    logic       in_use_carry = 1'b0;
    logic       clr_flags = 1'b0;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_opcode;
    logic       alu_carry_in;
    logic [7:0] alu_y;
    logic       alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_y;
    logic [4:0] out_flags;
    logic [7:0] err_count;
    logic       carry_flag;

    int checks = 0;
    int failures = 0;
    logic [12:0] sb[$];
    logic [12:0] held;
    bit          held_v = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.BUS_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .in_use_carry(in_use_carry),
        .clr_flags(clr_flags), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_carry_in(alu_carry_in), .alu_y(alu_y), .alu_carry_out(alu_carry_out),
        .alu_borrow(alu_borrow), .alu_zero(alu_zero), .alu_parity(alu_parity),
        .alu_invalid_op(alu_invalid_op), .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_flags(out_flags), .err_count(err_count), .carry_flag(carry_flag)
    );

    // Behavioural ALU: 1 ADD, 2 ADD_CARRY, 3 SUB, 4 INC, 5 DEC, 6 AND, 7 OR, 8 XOR, 9 PASS
    always_comb begin
        logic [8:0] wide;
        wide = 9'd0;
        alu_borrow = 1'b0;
        alu_invalid_op = 1'b0;
        case (alu_opcode)
            4'd1: wide = {1'b0, alu_a} + {1'b0, alu_b};
            4'd2: wide = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
            4'd3: begin wide = {1'b0, alu_a - alu_b}; alu_borrow = alu_a < alu_b; end
            4'd4: wide = {1'b0, alu_a} + 9'd1;
            4'd5: begin wide = {1'b0, alu_a - 8'd1}; alu_borrow = alu_a == 8'd0; end
            4'd6: wide = {1'b0, alu_a & alu_b};
            4'd7: wide = {1'b0, alu_a | alu_b};
            4'd8: wide = {1'b0, alu_a ^ alu_b};
            4'd9: wide = {1'b0, alu_a};
            default: alu_invalid_op = 1'b1;
        endcase
        alu_y = wide[7:0];
        alu_carry_out = wide[8];
        alu_zero = alu_y == 8'd0;
        alu_parity = ^alu_y;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Offer one op until accepted; expected result pushed at the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic uc, input logic [12:0] exp, input bit push);
        bit acc;
        int budget;
        in_valid = 1'b1; in_a = a; in_b = b; in_opcode = op; in_use_carry = uc;
        acc = 0;
        budget = 0;
        while (!acc && budget < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc && push) sb.push_back(exp);
            #1;
            budget++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 16'd0, 16'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 0;
        end else if (out_valid) begin
            if (held_v) begin
                checks++;
                if ({out_y, out_flags} !== held) begin
                    failures++;
                    $display("FAIL hold_stable actual=%h required=%h", {out_y, out_flags}, held);
                end
            end
            if (out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output actual=%h required=none", {out_y, out_flags});
                end else begin
                    logic [12:0] e;
                    e = sb.pop_front();
                    if ({out_y, out_flags} !== e) begin
                        failures++;
                        $display("FAIL result actual=y%h/f%b required=y%h/f%b", out_y, out_flags, e[12:5], e[4:0]);
                    end
                end
                held_v = 0;
            end else begin
                held = {out_y, out_flags};
                held_v = 1;
            end
        end
    end

    initial begin
        #12;
        check("reset_out_valid", {15'd0, out_valid}, 16'd0);
        check("reset_in_ready", {15'd0, in_ready}, 16'd1);
        check("reset_out_y_flags", {3'd0, out_y, out_flags}, 16'd0);
        check("reset_err_carry", {7'd0, err_count, carry_flag}, 16'd0);
        check("reset_alu_regs", {alu_a, alu_b[3:0], alu_opcode}, 16'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD latency
        send(8'h05, 8'h03, 4'd1, 1'b0, {8'h08, 5'b01000}, 1);
        check("add_lat_n", {15'd0, out_valid}, 16'd0);
        @(posedge clk); #1;
        check("add_lat_n1", {15'd0, out_valid}, 16'd1);
        idle(2);

        // Carry chain
        send(8'hFF, 8'h01, 4'd2, 1'b1, {8'h00, 5'b00101}, 1);
        send(8'h00, 8'h00, 4'd2, 1'b1, {8'h01, 5'b01000}, 1);
        check("chain_c_set", {15'd0, carry_flag}, 16'd1);
        idle(3);
        check("chain_c_clear", {15'd0, carry_flag}, 16'd0);

        send(8'h03, 8'h05, 4'd3, 1'b0, {8'hFE, 5'b01010}, 1);
        send(8'hF0, 8'h3C, 4'd6, 1'b0, {8'h30, 5'b00000}, 1);
        send(8'hAA, 8'hFF, 4'd8, 1'b0, {8'h55, 5'b00000}, 1);
        idle(3);

        // Backpressure
        out_ready = 1'b0;
        send(8'h10, 8'h20, 4'd1, 1'b0, {8'h30, 5'b00000}, 1);
        send(8'h01, 8'h01, 4'd1, 1'b0, {8'h02, 5'b01000}, 1);
        in_valid = 1'b1; in_a = 8'h07; in_b = 8'h00; in_opcode = 4'd1;
        idle(1);
        check("bp_in_ready_low", {15'd0, in_ready}, 16'd0);
        idle(3);
        check("bp_still_low", {15'd0, in_ready}, 16'd0);
        out_ready = 1'b1;
        send(8'h07, 8'h00, 4'd1, 1'b0, {8'h07, 5'b01000}, 1);
        idle(4);

        // Invalid opcodes and saturation
        send(8'h12, 8'h34, 4'd0, 1'b0, {8'h00, 5'b10100}, 1);
        send(8'h56, 8'h78, 4'd15, 1'b0, {8'h00, 5'b10100}, 1);
        idle(3);
        check("err_two", {8'd0, err_count}, 16'd2);
        for (int i = 0; i < 298; i++)
            send(8'(i), 8'h00, (i % 2 == 0) ? 4'd10 : 4'd13, 1'b0, {8'h00, 5'b10100}, 1);
        idle(3);
        check("err_saturate", {8'd0, err_count}, 16'h00FF);
        check("invalid_keeps_c", {15'd0, carry_flag}, 16'd0);

        // INC carry, then INC with clear on the transfer edge
        send(8'hFF, 8'h00, 4'd4, 1'b0, {8'h00, 5'b00101}, 1);
        idle(1);
        check("inc_sets_c", {15'd0, carry_flag}, 16'd1);
        send(8'hFF, 8'h00, 4'd4, 1'b0, {8'h00, 5'b00101}, 1);
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        check("clr_wins", {15'd0, carry_flag}, 16'd0);
        idle(3);

        // Reset with both stages full
        out_ready = 1'b0;
        send(8'hFF, 8'h00, 4'd4, 1'b0, 13'd0, 0);
        send(8'h00, 8'h00, 4'd0, 1'b0, 13'd0, 0);
        idle(1);
        check("pre_rst_full", {14'd0, out_valid, in_ready}, 16'd2);
        check("pre_rst_c", {15'd0, carry_flag}, 16'd1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_out_valid_in_ready", {14'd0, out_valid, in_ready}, 16'd1);
        check("rst_c_err", {7'd0, err_count, carry_flag}, 16'd0);
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b1;
        idle(4);
        check("no_stale_out", {15'd0, out_valid}, 16'd0);
        check("scoreboard_empty", 16'(sb.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
